// File: rtl/mem_stage_unit_pkg.sv
// mem_stage_unit_pkg: op codes, FSM states and stack defaults shared by the memory stage.
package mem_stage_unit_pkg;

   localparam logic [15:0] SP_INIT_DEF = 16'h07FF;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_LOAD   = 3'd1,
      OP_STORE  = 3'd2,
      OP_PUSH   = 3'd3,
      OP_POP    = 3'd4,
      OP_PUSH32 = 3'd5,
      OP_POP32  = 3'd6,
      OP_RSVD   = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      PUSH_LO  = 3'd2,
      POP_2    = 3'd3,
      POP_WAIT = 3'd4
   } state_e;

   // The reserved encoding behaves exactly like a plain ALU pass-through.
   function automatic logic is_alu(input logic [2:0] op);
      return (op == OP_NOP) || (op == OP_RSVD);
   endfunction

endpackage

// File: rtl/stack_pointer_reg.sv
// stack_pointer_reg: stack pointer with async reset to INIT, inc/dec/hold, and a precomputed SP+1.
module stack_pointer_reg
   import mem_stage_unit_pkg::*;
#(
   parameter int W = 16,
   parameter logic [W-1:0] INIT = W'(SP_INIT_DEF)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] sp,
   output logic [W-1:0] sp_plus1
);

   assign sp_plus1 = sp + W'(1);

   always_ff @(posedge clk or posedge reset)
      if (reset)
         sp <= INIT;
      else if (inc)
         sp <= sp_plus1;
      else if (dec)
         sp <= sp - W'(1);

endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: memory-stage engine that drives data memory, owns SP, sequences
// one/two-word stack accesses and produces registered MEM/WB fields.
module mem_stage_unit
   import mem_stage_unit_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_INIT_DEF)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            op_in,
   input  logic                  reg_write_in,
   input  logic [DATA_W-1:0]     result_in,
   input  logic [DATA_W-1:0]     result_hi_in,
   input  logic [ADDR_W-1:0]     address_in,
   input  logic [2:0]            reg_dst_in,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic                  stall,
   output logic                  wb_valid,
   output logic                  wb_en,
   output logic [2:0]            wb_reg_num,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  pc_load,
   output logic [2*DATA_W-1:0]   pc_out
);

   state_e            state, next;
   logic              sp_inc, sp_dec;
   logic [ADDR_W-1:0] sp, sp_plus1;
   logic [DATA_W-1:0] lo_q;
   logic [2:0]        dst_q;
   logic              rw_q;

   stack_pointer_reg #(.W(ADDR_W), .INIT(SP_INIT)) u_sp (
      .clk      (clk),
      .reset    (reset),
      .inc      (sp_inc),
      .dec      (sp_dec),
      .sp       (sp),
      .sp_plus1 (sp_plus1)
   );

   // Memory strobes are combinational, so they are gated by reset to stay quiet while it is held.
   always_comb begin
      next      = state;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      stall     = 1'b0;
      sp_inc    = 1'b0;
      sp_dec    = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               case (op_in)
                  OP_LOAD: begin
                     mem_re = 1'b1; mem_addr = address_in; stall = 1'b1; next = RD_WAIT;
                  end
                  OP_STORE: begin
                     mem_we = 1'b1; mem_addr = address_in; mem_wdata = result_in;
                  end
                  OP_PUSH: begin
                     mem_we = 1'b1; mem_addr = sp; mem_wdata = result_in; sp_dec = 1'b1;
                  end
                  OP_POP: begin
                     mem_re = 1'b1; mem_addr = sp_plus1; sp_inc = 1'b1; stall = 1'b1; next = RD_WAIT;
                  end
                  OP_PUSH32: begin
                     mem_we = 1'b1; mem_addr = sp; mem_wdata = result_hi_in; sp_dec = 1'b1;
                     stall = 1'b1; next = PUSH_LO;
                  end
                  OP_POP32: begin
                     mem_re = 1'b1; mem_addr = sp_plus1; sp_inc = 1'b1; stall = 1'b1; next = POP_2;
                  end
                  default: ;
               endcase
            end
            PUSH_LO: begin
               mem_we = 1'b1; mem_addr = sp; mem_wdata = result_in; sp_dec = 1'b1; next = IDLE;
            end
            POP_2: begin
               mem_re = 1'b1; mem_addr = sp_plus1; sp_inc = 1'b1; stall = 1'b1; next = POP_WAIT;
            end
            default: next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         wb_valid   <= 1'b0;
         wb_en      <= 1'b0;
         wb_reg_num <= '0;
         wb_data    <= '0;
         pc_load    <= 1'b0;
         pc_out     <= '0;
         lo_q       <= '0;
         dst_q      <= '0;
         rw_q       <= 1'b0;
      end else begin
         state    <= next;
         wb_valid <= 1'b0;
         pc_load  <= 1'b0;
         case (state)
            IDLE: begin
               dst_q <= reg_dst_in;
               rw_q  <= reg_write_in;
               if (next == IDLE) begin
                  wb_valid   <= 1'b1;
                  wb_reg_num <= reg_dst_in;
                  wb_en      <= is_alu(op_in) && reg_write_in;
                  if (is_alu(op_in))
                     wb_data <= result_in;
               end
            end
            RD_WAIT: begin
               wb_valid   <= 1'b1;
               wb_en      <= rw_q;
               wb_reg_num <= dst_q;
               wb_data    <= mem_rdata;
            end
            PUSH_LO: begin
               wb_valid   <= 1'b1;
               wb_en      <= 1'b0;
               wb_reg_num <= dst_q;
            end
            POP_2: lo_q <= mem_rdata;
            POP_WAIT: begin
               pc_out     <= {mem_rdata, lo_q};
               pc_load    <= 1'b1;
               wb_valid   <= 1'b1;
               wb_en      <= 1'b0;
               wb_reg_num <= dst_q;
            end
            default: ;
         endcase
      end

endmodule
